// File: rtl/pipeline_latch_chain.sv
// Chain of STAGES pipeline latches (latch 0 youngest) carrying IR/PC/control word,
// with valid bits, stall back-pressure, stall-bubble counting and depth-selectable flush.
module pipeline_latch_chain #(
  parameter int unsigned     WIDTH    = 16,
  parameter int unsigned     CW_WIDTH = 32,
  parameter int unsigned     STAGES   = 4,
  parameter logic [WIDTH-1:0] NOP_IR  = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_ir,
  input  logic [WIDTH-1:0]             in_pc,
  input  logic [CW_WIDTH-1:0]          in_cw,
  input  logic [STAGES-1:0]            stall_req,
  input  logic                         flush,
  input  logic [$clog2(STAGES+1)-1:0]  flush_depth,
  output logic                         in_ready,
  output logic [STAGES-1:0]            stage_valid,
  output logic [STAGES*WIDTH-1:0]      stage_ir,
  output logic [STAGES*WIDTH-1:0]      stage_pc,
  output logic [STAGES*CW_WIDTH-1:0]   stage_cw,
  output logic [15:0]                  bubble_count
);

  logic [STAGES-1:0]   valid_q;
  logic [WIDTH-1:0]    ir_q [STAGES];
  logic [WIDTH-1:0]    pc_q [STAGES];
  logic [CW_WIDTH-1:0] cw_q [STAGES];

  logic [STAGES-1:0]   hold;
  logic [STAGES-1:0]   flush_kill;   // rule: flushed outright (k < fd)
  logic [STAGES-1:0]   edge_kill;    // rule: latch whose older neighbour is being flushed
  logic [STAGES-1:0]   stall_bub;    // rule: counted stall bubble
  int unsigned         fd;
  int unsigned         n_bub;
  logic [16:0]         count_sum;
  logic [15:0]         count_next;

  // hold propagates from the oldest stalled valid latch down to latch 0
  always_comb begin
    hold = '0;
    hold[STAGES-1] = stall_req[STAGES-1] & valid_q[STAGES-1];
    for (int unsigned i = 0; i < STAGES - 1; i++) begin
      hold[STAGES-2-i] = (stall_req[STAGES-2-i] & valid_q[STAGES-2-i]) | hold[STAGES-1-i];
    end
  end

  always_comb begin
    fd = 32'(flush_depth);
    if (fd > STAGES) fd = STAGES;
    flush_kill = '0;
    edge_kill  = '0;
    stall_bub  = '0;
    n_bub      = 0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      flush_kill[k] = flush && (k < fd);
      if (k > 0) begin
        edge_kill[k] = flush && (k == fd);
        stall_bub[k] = !flush_kill[k] && !hold[k] && !edge_kill[k] && hold[k-1];
        if (stall_bub[k]) n_bub++;
      end
    end
    count_sum  = {1'b0, bubble_count} + 17'(n_bub);
    count_next = count_sum[16] ? '1 : count_sum[15:0];
    in_ready   = !hold[0] && !(flush && fd != 0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= '0;
      bubble_count <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        ir_q[k] <= NOP_IR;
        pc_q[k] <= '0;
        cw_q[k] <= '0;
      end
    end else begin
      bubble_count <= count_next;
      if (flush_kill[0]) begin
        valid_q[0] <= 1'b0;
        ir_q[0]    <= NOP_IR;
        pc_q[0]    <= '0;
        cw_q[0]    <= '0;
      end else if (!hold[0]) begin
        valid_q[0] <= in_valid;
        ir_q[0]    <= in_ir;
        pc_q[0]    <= in_pc;
        cw_q[0]    <= in_cw;
      end
      for (int unsigned k = 1; k < STAGES; k++) begin
        if (flush_kill[k] || (!hold[k] && (edge_kill[k] || hold[k-1]))) begin
          valid_q[k] <= 1'b0;
          ir_q[k]    <= NOP_IR;
          pc_q[k]    <= '0;
          cw_q[k]    <= '0;
        end else if (!hold[k]) begin
          valid_q[k] <= valid_q[k-1];
          ir_q[k]    <= ir_q[k-1];
          pc_q[k]    <= pc_q[k-1];
          cw_q[k]    <= cw_q[k-1];
        end
      end
    end
  end

  always_comb begin
    stage_valid = valid_q;
    stage_ir    = '0;
    stage_pc    = '0;
    stage_cw    = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      stage_ir[k*WIDTH +: WIDTH]       = ir_q[k];
      stage_pc[k*WIDTH +: WIDTH]       = pc_q[k];
      stage_cw[k*CW_WIDTH +: CW_WIDTH] = cw_q[k];
    end
  end

endmodule

// File: tb/tb_pipeline_latch_chain.sv
// Directed bench for pipeline_latch_chain (STAGES=4): streaming, stall bubbles,
// ignored stalls, flush depths, counter saturation and asynchronous reset.
module tb_pipeline_latch_chain;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 32;
  localparam int unsigned S  = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic [W-1:0]    in_ir;
  logic [W-1:0]    in_pc;
  logic [CW-1:0]   in_cw;
  logic [S-1:0]    stall_req;
  logic            flush;
  logic [2:0]      flush_depth;
  logic            in_ready;
  logic [S-1:0]    stage_valid;
  logic [S*W-1:0]  stage_ir;
  logic [S*W-1:0]  stage_pc;
  logic [S*CW-1:0] stage_cw;
  logic [15:0]     bubble_count;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_latch_chain #(
    .WIDTH(W), .CW_WIDTH(CW), .STAGES(S), .NOP_IR(16'h0000)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ir(in_ir), .in_pc(in_pc),
    .in_cw(in_cw), .stall_req(stall_req), .flush(flush), .flush_depth(flush_depth),
    .in_ready(in_ready), .stage_valid(stage_valid), .stage_ir(stage_ir),
    .stage_pc(stage_pc), .stage_cw(stage_cw), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pc_of(input int k);
    return stage_pc[k*W +: W];
  endfunction

  function automatic logic [W-1:0] ir_of(input int k);
    return stage_ir[k*W +: W];
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_ir    = 16'h1000 | pc;
    in_cw    = {16'hC0DE, pc};
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    stall_req = '0;
    flush = 1'b0;
    flush_depth = '0;
    drive(1'b0, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_valid", 64'(stage_valid), 64'h0);
    check_eq("reset_ir0", 64'(ir_of(0)), 64'h0);
    check_eq("reset_bubbles", 64'(bubble_count), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // T1: stream PCs 0,2,4,... ; edge n carries pc 2(n-1)
    for (int n = 1; n <= 6; n++) begin
      drive(1'b1, 16'(2 * (n - 1)));
      tick;
      if (n == 1) begin
        check_eq("t1_ir0", 64'(ir_of(0)), 64'h1000);
        check_eq("t1_cw0", 64'(stage_cw[CW-1:0]), 64'hC0DE0000);
      end
      if (n >= 4) check_eq($sformatf("t1_pc3_e%0d", n), 64'(pc_of(3)), 64'(2 * (n - 4)));
    end
    check_eq("t1_valid", 64'(stage_valid), 64'hF);

    // T2: stall latch 2 for one cycle
    drive(1'b1, 16'd12);
    stall_req = 4'b0100;
    #1;
    check_eq("t2_in_ready", 64'(in_ready), 64'h0);
    tick;
    check_eq("t2_valid", 64'(stage_valid), 64'b0111);
    check_eq("t2_ir3_nop", 64'(ir_of(3)), 64'h0);
    check_eq("t2_pc2_held", 64'(pc_of(2)), 64'd6);
    check_eq("t2_pc0_held", 64'(pc_of(0)), 64'd10);
    check_eq("t2_bubbles", 64'(bubble_count), 64'd1);
    stall_req = '0;
    tick;
    check_eq("t2_resume_pc3", 64'(pc_of(3)), 64'd6);
    check_eq("t2_resume_pc0", 64'(pc_of(0)), 64'd12);

    // T3: stall on an invalid latch 1 is ignored
    drive(1'b0, 16'd14);
    tick;
    drive(1'b1, 16'd16);
    tick;
    check_eq("t3_valid_pre", 64'(stage_valid), 64'b1101);
    drive(1'b1, 16'd18);
    stall_req = 4'b0010;
    #1;
    check_eq("t3_in_ready", 64'(in_ready), 64'h1);
    tick;
    check_eq("t3_valid", 64'(stage_valid), 64'b1011);
    check_eq("t3_pc3", 64'(pc_of(3)), 64'd12);
    check_eq("t3_pc1", 64'(pc_of(1)), 64'd16);
    check_eq("t3_bubbles", 64'(bubble_count), 64'd1);
    stall_req = '0;
    drive(1'b1, 16'd20);
    tick;
    check_eq("t4_pre_valid", 64'(stage_valid), 64'b0111);

    // T4: flush depth 2 with a simultaneous stall on latch 0
    drive(1'b1, 16'd22);
    stall_req = 4'b0001;
    flush = 1'b1;
    flush_depth = 3'd2;
    #1;
    check_eq("t4_in_ready", 64'(in_ready), 64'h0);
    tick;
    check_eq("t4_valid", 64'(stage_valid), 64'b1000);
    check_eq("t4_pc3", 64'(pc_of(3)), 64'd16);
    check_eq("t4_ir2_nop", 64'(ir_of(2)), 64'h0);
    check_eq("t4_pc2", 64'(pc_of(2)), 64'h0);
    check_eq("t4_bubbles", 64'(bubble_count), 64'd1);
    stall_req = '0;

    // flush with depth 0 has no effect
    flush_depth = 3'd0;
    drive(1'b1, 16'd22);
    #1;
    check_eq("fd0_in_ready", 64'(in_ready), 64'h1);
    tick;
    check_eq("fd0_valid0", 64'(stage_valid[0]), 64'h1);
    flush = 1'b0;
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, 16'(24 + 2 * n));
      tick;
    end
    check_eq("t5_pre_valid", 64'(stage_valid), 64'hF);
    check_eq("t5_pre_pc3", 64'(pc_of(3)), 64'd22);

    // T5: flush depth beyond STAGES clamps to all latches
    drive(1'b1, 16'd30);
    flush = 1'b1;
    flush_depth = 3'd7;
    #1;
    check_eq("t5_in_ready", 64'(in_ready), 64'h0);
    tick;
    check_eq("t5_valid", 64'(stage_valid), 64'h0);
    check_eq("t5_pc3", 64'(pc_of(3)), 64'h0);
    check_eq("t5_bubbles", 64'(bubble_count), 64'd1);
    flush = 1'b0;
    flush_depth = '0;

    // T6: continuous stall on latch 2 yields one bubble per edge until saturation
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, 16'(32 + 2 * n));
      tick;
    end
    drive(1'b1, 16'd38);
    stall_req = 4'b0100;
    repeat (100) tick;
    check_eq("t6_bubbles_100", 64'(bubble_count), 64'd101);
    check_eq("t6_valid", 64'(stage_valid), 64'b0111);
    repeat (69900) tick;
    check_eq("t6_saturated", 64'(bubble_count), 64'hFFFF);

    // asynchronous reset mid-cycle
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_valid", 64'(stage_valid), 64'h0);
    check_eq("arst_bubbles", 64'(bubble_count), 64'h0);
    check_eq("arst_pc", 64'(stage_pc), 64'h0);
    check_eq("arst_cw", 64'(stage_cw), 64'h0);
    check_eq("arst_ir", 64'(stage_ir), 64'h0);
    check_eq("arst_in_ready", 64'(in_ready), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
